// File: rtl/ps2_host.sv
// PS/2 host controller: deglitched receive with prefix decode into a key-event
// FIFO, host-to-device command transmit, and an inter-edge timeout.
module ps2_host #(
   parameter int unsigned FILTER_LEN     = 16,
   parameter int unsigned TIMEOUT_W      = 16,
   parameter int unsigned FIFO_DEPTH     = 8,
   parameter int unsigned INHIBIT_CYCLES = 5000
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ps2_clk_i,
   input  logic                          ps2_data_i,
   output logic                          ps2_clk_oe,
   output logic                          ps2_data_oe,
   input  logic                          rd_en,
   output logic [9:0]                    key_out,
   output logic                          rx_empty,
   output logic [$clog2(FIFO_DEPTH):0]   rx_count,
   output logic                          overflow,
   output logic                          rx_err,
   input  logic [7:0]                    tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          tx_done,
   output logic                          tx_err
);

   localparam int unsigned Q     = FILTER_LEN / 4;
   localparam int unsigned PW    = $clog2(FIFO_DEPTH);
   localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [PW:0]      FULL_CNT = (PW + 1)'(FIFO_DEPTH);

   typedef enum logic [3:0] {
      IDLE, RX_DATA, RX_PARITY, RX_STOP,
      TX_INHIBIT, TX_DATA, TX_PARITY, TX_STOP, TX_ACK
   } state_t;

   state_t                state, state_nx;
   logic                  clk_s1, clk_s2, data_s1, data_s2;
   logic [FILTER_LEN-1:0] hist;
   logic                  fall;
   logic [2:0]            bit_cnt, bit_cnt_nx;
   logic [7:0]            shreg, shreg_nx;
   logic                  par_q, par_nx;
   logic                  clk_oe_q, clk_oe_nx, data_oe_q, data_oe_nx;
   logic                  ext_q, ext_nx, rel_q, rel_nx;
   logic [INH_W-1:0]      inh_cnt, inh_nx;
   logic [TIMEOUT_W-1:0]  to_cnt;
   logic                  active, is_tx, timeout;
   logic                  rx_err_nx, tx_done_nx, tx_err_nx;
   logic                  push;
   logic [9:0]            push_word;
   logic [9:0]            mem [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [PW:0]           count;
   logic                  pop, wr_ok, drop;

   // Two-flop synchronisers and clock history; idle-high so reset release is quiet
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_s1  <= 1'b1;
         clk_s2  <= 1'b1;
         data_s1 <= 1'b1;
         data_s2 <= 1'b1;
         hist    <= '1;
      end else begin
         clk_s1  <= ps2_clk_i;
         clk_s2  <= clk_s1;
         data_s1 <= ps2_data_i;
         data_s2 <= data_s1;
         hist    <= {hist[FILTER_LEN-2:0], clk_s2};
      end
   end

   // Falling edge: oldest quarter high, newest three quarters low (one-cycle strobe)
   assign fall    = (&hist[FILTER_LEN-1 -: Q]) && (hist[FILTER_LEN-Q-1:0] == '0);
   assign active  = (state != IDLE) && (state != TX_INHIBIT);
   assign is_tx   = (state == TX_DATA) || (state == TX_PARITY) ||
                    (state == TX_STOP) || (state == TX_ACK);
   assign timeout = active && (&to_cnt) && !fall;

   // FSM state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         par_q     <= 1'b0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         ext_q     <= 1'b0;
         rel_q     <= 1'b0;
         inh_cnt   <= '0;
         rx_err    <= 1'b0;
         tx_done   <= 1'b0;
         tx_err    <= 1'b0;
      end else begin
         state     <= state_nx;
         bit_cnt   <= bit_cnt_nx;
         shreg     <= shreg_nx;
         par_q     <= par_nx;
         clk_oe_q  <= clk_oe_nx;
         data_oe_q <= data_oe_nx;
         ext_q     <= ext_nx;
         rel_q     <= rel_nx;
         inh_cnt   <= inh_nx;
         rx_err    <= rx_err_nx;
         tx_done   <= tx_done_nx;
         tx_err    <= tx_err_nx;
      end
   end

   // Next-state logic for receive, transmit and timeout recovery
   always_comb begin
      state_nx   = state;
      bit_cnt_nx = bit_cnt;
      shreg_nx   = shreg;
      par_nx     = par_q;
      clk_oe_nx  = clk_oe_q;
      data_oe_nx = data_oe_q;
      ext_nx     = ext_q;
      rel_nx     = rel_q;
      inh_nx     = inh_cnt;
      rx_err_nx  = 1'b0;
      tx_done_nx = 1'b0;
      tx_err_nx  = 1'b0;
      push       = 1'b0;
      push_word  = {rel_q, ext_q, shreg};
      case (state)
         IDLE: begin
            if (tx_valid) begin
               state_nx  = TX_INHIBIT;
               shreg_nx  = tx_data;
               par_nx    = ~^tx_data;
               clk_oe_nx = 1'b1;
               inh_nx    = '0;
            end else if (fall && !data_s2) begin
               state_nx   = RX_DATA;
               bit_cnt_nx = '0;
            end
         end
         RX_DATA: begin
            if (fall) begin
               shreg_nx   = {data_s2, shreg[7:1]};
               bit_cnt_nx = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_nx = RX_PARITY;
            end
         end
         RX_PARITY: begin
            if (fall) begin
               if (^{shreg, data_s2}) begin
                  state_nx = RX_STOP;
               end else begin
                  state_nx  = IDLE;
                  rx_err_nx = 1'b1;
                  ext_nx    = 1'b0;
                  rel_nx    = 1'b0;
               end
            end
         end
         RX_STOP: begin
            if (fall) begin
               state_nx = IDLE;
               if (!data_s2) begin
                  rx_err_nx = 1'b1;
                  ext_nx    = 1'b0;
                  rel_nx    = 1'b0;
               end else if (shreg == 8'hE0) begin
                  ext_nx = 1'b1;
               end else if (shreg == 8'hF0) begin
                  rel_nx = 1'b1;
               end else begin
                  push   = 1'b1;
                  ext_nx = 1'b0;
                  rel_nx = 1'b0;
               end
            end
         end
         TX_INHIBIT: begin
            if (inh_cnt == INH_LAST) begin
               state_nx   = TX_DATA;
               clk_oe_nx  = 1'b0;
               data_oe_nx = 1'b1;
               bit_cnt_nx = '0;
            end else begin
               inh_nx = inh_cnt + INH_W'(1);
            end
         end
         TX_DATA: begin
            if (fall) begin
               data_oe_nx = ~shreg[0];
               shreg_nx   = {1'b0, shreg[7:1]};
               bit_cnt_nx = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_nx = TX_PARITY;
            end
         end
         TX_PARITY: begin
            if (fall) begin
               data_oe_nx = ~par_q;
               state_nx   = TX_STOP;
            end
         end
         TX_STOP: begin
            if (fall) begin
               data_oe_nx = 1'b0;
               state_nx   = TX_ACK;
            end
         end
         TX_ACK: begin
            if (fall) begin
               state_nx = IDLE;
               if (!data_s2) tx_done_nx = 1'b1;
               else          tx_err_nx  = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
      if (timeout) begin
         state_nx   = IDLE;
         clk_oe_nx  = 1'b0;
         data_oe_nx = 1'b0;
         ext_nx     = 1'b0;
         rel_nx     = 1'b0;
         push       = 1'b0;
         rx_err_nx  = 1'b0;
         tx_done_nx = 1'b0;
         tx_err_nx  = is_tx;
      end
   end

   // Inter-edge timeout counter, cleared on every edge and every state change
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt <= '0;
      end else if (fall || (state_nx != state) || !active) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt + TIMEOUT_W'(1);
      end
   end

   assign pop   = rd_en && (count != '0);
   assign wr_ok = push && ((count != FULL_CNT) || pop);
   assign drop  = push && (count == FULL_CNT) && !pop;

   // FIFO pointers, occupancy and sticky overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop)   rd_ptr <= rd_ptr + PW'(1);
         case ({wr_ok, pop})
            2'b10:   count <= count + (PW + 1)'(1);
            2'b01:   count <= count - (PW + 1)'(1);
            default: count <= count;
         endcase
         if (pop)       overflow <= 1'b0;
         else if (drop) overflow <= 1'b1;
      end
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= push_word;
   end

   assign key_out     = mem[rd_ptr];
   assign rx_empty    = (count == '0);
   assign rx_count    = count;
   assign tx_ready    = (state == IDLE);
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host.sv
// Directed bench for ps2_host: a PS/2 device model on open-drain pads,
// receive/prefix/error/FIFO/transmit/timeout/reset scenarios.
module tb_ps2_host;

   localparam int H = 20;   // device half clock period in system cycles

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
   logic       ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe;
   logic       rd_en = 1'b0;
   logic [9:0] key_out;
   logic       rx_empty, overflow, rx_err;
   logic [3:0] rx_count;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, tx_done, tx_err;

   int compared = 0, mismatched = 0;
   int rx_err_cnt = 0, tx_done_cnt = 0, tx_err_cnt = 0;
   int push_lat = 0;

   always #5 clk = ~clk;

   assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

   ps2_host #(.FILTER_LEN(16), .TIMEOUT_W(8), .FIFO_DEPTH(8), .INHIBIT_CYCLES(5000)) dut (
      .clk(clk), .rst_n(rst_n), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
      .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .rd_en(rd_en),
      .key_out(key_out), .rx_empty(rx_empty), .rx_count(rx_count),
      .overflow(overflow), .rx_err(rx_err), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .tx_done(tx_done), .tx_err(tx_err)
   );

   always @(posedge clk) begin
      if (rx_err)  rx_err_cnt  <= rx_err_cnt + 1;
      if (tx_done) tx_done_cnt <= tx_done_cnt + 1;
      if (tx_err)  tx_err_cnt  <= tx_err_cnt + 1;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pop_one();
      @(negedge clk); rd_en = 1'b1;
      @(negedge clk); rd_en = 1'b0;
   endtask

   // Device-to-host frame; pop_at>0 raises rd_en so it coincides with the push
   task automatic send_frame(input logic [7:0] b, input logic bad_par,
                             input logic bad_stop, input int pop_at);
      logic [10:0] f;
      int c0;
      f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int k = 0; k < 11; k++) begin
         dev_data_low = ~f[k];
         wait_cyc(H);
         dev_clk_low = 1'b1;
         c0 = int'(rx_count);
         for (int i = 1; i <= H; i++) begin
            @(negedge clk);
            if (k == 10) begin
               if (pop_at > 0 && i == pop_at - 1) rd_en = 1'b1;
               if (i == pop_at) rd_en = 1'b0;
               if (push_lat == 0 && int'(rx_count) != c0) push_lat = i;
            end
         end
         dev_clk_low = 1'b0;
      end
      dev_data_low = 1'b0;
      wait_cyc(H);
   endtask

   task automatic send_partial(input logic [7:0] b, input int nbits);
      logic [8:0] f;
      f = {b, 1'b0};
      for (int k = 0; k <= nbits; k++) begin
         dev_data_low = ~f[k];
         wait_cyc(H);
         dev_clk_low = 1'b1;
         wait_cyc(H);
         dev_clk_low = 1'b0;
      end
      dev_data_low = 1'b0;
   endtask

   task automatic start_tx(input logic [7:0] d, output logic rdy1, output int inh,
                           output logic start_oe);
      @(negedge clk); tx_data = d; tx_valid = 1'b1;
      @(negedge clk); tx_valid = 1'b0;
      rdy1 = tx_ready;
      inh = 0;
      while (ps2_clk_oe && inh < 6000) begin
         inh++;
         @(negedge clk);
      end
      start_oe = ps2_data_oe;
   endtask

   task automatic tx_device(input logic ack_low, output logic [9:0] got);
      got = '0;
      wait_cyc(10);
      for (int k = 1; k <= 11; k++) begin
         if (k == 11) dev_data_low = ack_low;
         wait_cyc(H);
         dev_clk_low = 1'b1;
         wait_cyc(H);
         if (k <= 10) got[k-1] = ps2_data_i;
         dev_clk_low = 1'b0;
      end
      wait_cyc(H);
      dev_data_low = 1'b0;
      wait_cyc(H);
   endtask

   task automatic test_reset();
      wait_cyc(3);
      compared++; if (ps2_clk_oe !== 1'b0) begin mismatched++; $display("FAIL rst_clk_oe: got %b want 0", ps2_clk_oe); end
      compared++; if (ps2_data_oe !== 1'b0) begin mismatched++; $display("FAIL rst_data_oe: got %b want 0", ps2_data_oe); end
      compared++; if (rx_empty !== 1'b1) begin mismatched++; $display("FAIL rst_empty: got %b want 1", rx_empty); end
      compared++; if (rx_count !== 4'd0) begin mismatched++; $display("FAIL rst_count: got %0d want 0", rx_count); end
      compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL rst_overflow: got %b want 0", overflow); end
      compared++; if (tx_ready !== 1'b1) begin mismatched++; $display("FAIL rst_tx_ready: got %b want 1", tx_ready); end
      compared++; if ({rx_err, tx_done, tx_err} !== 3'b000) begin mismatched++; $display("FAIL rst_pulses: got %b want 000", {rx_err, tx_done, tx_err}); end
      @(negedge clk); rst_n = 1'b1;
      wait_cyc(40);
      compared++; if (rx_count !== 4'd0 || rx_err_cnt != 0) begin mismatched++; $display("FAIL rst_release_quiet: count %0d errs %0d want 0 0", rx_count, rx_err_cnt); end
   endtask

   task automatic test_rx_basic();
      send_frame(8'h1C, 1'b0, 1'b0, 0);
      compared++; if (rx_count !== 4'd1) begin mismatched++; $display("FAIL rx_count: got %0d want 1", rx_count); end
      compared++; if (key_out !== 10'h01C) begin mismatched++; $display("FAIL rx_key: got %h want 01c", key_out); end
      pop_one();
      compared++; if (rx_empty !== 1'b1) begin mismatched++; $display("FAIL rx_pop_empty: got %b want 1", rx_empty); end
   endtask

   task automatic test_prefix();
      send_frame(8'hE0, 1'b0, 1'b0, 0);
      send_frame(8'hF0, 1'b0, 1'b0, 0);
      send_frame(8'h75, 1'b0, 1'b0, 0);
      compared++; if (rx_count !== 4'd1) begin mismatched++; $display("FAIL pfx_count: got %0d want 1", rx_count); end
      compared++; if (key_out !== 10'h375) begin mismatched++; $display("FAIL pfx_key: got %h want 375", key_out); end
      pop_one();
      send_frame(8'h1C, 1'b0, 1'b0, 0);
      compared++; if (key_out !== 10'h01C) begin mismatched++; $display("FAIL pfx_cleared: got %h want 01c", key_out); end
      pop_one();
   endtask

   task automatic test_errors();
      int e0;
      e0 = rx_err_cnt;
      send_frame(8'h1C, 1'b1, 1'b0, 0);
      compared++; if (rx_err_cnt - e0 != 1) begin mismatched++; $display("FAIL par_err_pulses: got %0d want 1", rx_err_cnt - e0); end
      compared++; if (rx_count !== 4'd0) begin mismatched++; $display("FAIL par_err_fifo: got %0d want 0", rx_count); end
      e0 = rx_err_cnt;
      send_frame(8'h1C, 1'b0, 1'b1, 0);
      compared++; if (rx_err_cnt - e0 != 1) begin mismatched++; $display("FAIL stop_err_pulses: got %0d want 1", rx_err_cnt - e0); end
      compared++; if (rx_count !== 4'd0) begin mismatched++; $display("FAIL stop_err_fifo: got %0d want 0", rx_count); end
      send_frame(8'hE0, 1'b0, 1'b0, 0);
      send_frame(8'h75, 1'b1, 1'b0, 0);
      send_frame(8'h1C, 1'b0, 1'b0, 0);
      compared++; if (key_out !== 10'h01C || rx_count !== 4'd1) begin mismatched++; $display("FAIL err_clears_prefix: got %h/%0d want 01c/1", key_out, rx_count); end
      pop_one();
   endtask

   task automatic test_overflow();
      logic [7:0] exp_q [8];
      int pat;
      for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b0, 0);
      compared++; if (rx_count !== 4'd8 || overflow !== 1'b0) begin mismatched++; $display("FAIL ovf_fill: count %0d ovf %b want 8 0", rx_count, overflow); end
      send_frame(8'h09, 1'b0, 1'b0, 0);
      compared++; if (rx_count !== 4'd8) begin mismatched++; $display("FAIL ovf_count: got %0d want 8", rx_count); end
      compared++; if (overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_flag: got %b want 1", overflow); end
      compared++; if (key_out !== 10'h001) begin mismatched++; $display("FAIL ovf_head: got %h want 001", key_out); end
      pat = (push_lat > 1) ? push_lat : 15;
      send_frame(8'h0A, 1'b0, 1'b0, pat);
      compared++; if (rx_count !== 4'd8) begin mismatched++; $display("FAIL ovf_poppush_count: got %0d want 8", rx_count); end
      compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL ovf_cleared: got %b want 0", overflow); end
      exp_q = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
      for (int i = 0; i < 8; i++) begin
         compared++; if (key_out !== {2'b00, exp_q[i]}) begin mismatched++; $display("FAIL ovf_drain%0d: got %h want %h", i, key_out, {2'b00, exp_q[i]}); end
         pop_one();
      end
      compared++; if (rx_empty !== 1'b1) begin mismatched++; $display("FAIL ovf_empty: got %b want 1", rx_empty); end
      pop_one();
      compared++; if (rx_count !== 4'd0) begin mismatched++; $display("FAIL pop_on_empty: got %0d want 0", rx_count); end
   endtask

   task automatic test_tx(input logic ack_low);
      logic rdy1, start_oe;
      logic [9:0] got;
      int inh, d0, e0;
      d0 = tx_done_cnt; e0 = tx_err_cnt;
      start_tx(8'hED, rdy1, inh, start_oe);
      compared++; if (rdy1 !== 1'b0) begin mismatched++; $display("FAIL tx_ready_fall: got %b want 0", rdy1); end
      compared++; if (inh != 5000) begin mismatched++; $display("FAIL tx_inhibit_len: got %0d want 5000", inh); end
      compared++; if (start_oe !== 1'b1) begin mismatched++; $display("FAIL tx_start_bit: got %b want 1", start_oe); end
      tx_device(ack_low, got);
      compared++; if (got !== 10'b11_1110_1101) begin mismatched++; $display("FAIL tx_bits: got %b want 1111101101", got); end
      if (ack_low) begin
         compared++; if (tx_done_cnt - d0 != 1 || tx_err_cnt != e0) begin mismatched++; $display("FAIL tx_ack_done: done %0d err %0d want 1 0", tx_done_cnt - d0, tx_err_cnt - e0); end
      end else begin
         compared++; if (tx_err_cnt - e0 != 1 || tx_done_cnt != d0) begin mismatched++; $display("FAIL tx_noack_err: err %0d done %0d want 1 0", tx_err_cnt - e0, tx_done_cnt - d0); end
      end
      compared++; if (tx_ready !== 1'b1 || rx_count !== 4'd0) begin mismatched++; $display("FAIL tx_end_state: ready %b count %0d want 1 0", tx_ready, rx_count); end
   endtask

   task automatic test_device_response();
      send_frame(8'hFA, 1'b0, 1'b0, 0);
      compared++; if (key_out !== 10'h0FA || rx_count !== 4'd1) begin mismatched++; $display("FAIL resp_fa: got %h/%0d want 0fa/1", key_out, rx_count); end
      pop_one();
   endtask

   task automatic test_timeout();
      int e0, t0;
      e0 = rx_err_cnt; t0 = tx_err_cnt;
      send_partial(8'h1C, 3);
      wait_cyc(200);
      compared++; if (tx_ready !== 1'b0) begin mismatched++; $display("FAIL to_still_busy: got %b want 0", tx_ready); end
      wait_cyc(100);
      compared++; if (tx_ready !== 1'b1) begin mismatched++; $display("FAIL to_idle: got %b want 1", tx_ready); end
      compared++; if (rx_count !== 4'd0 || rx_err_cnt != e0 || tx_err_cnt != t0) begin mismatched++; $display("FAIL to_side_effects: count %0d rxerr %0d txerr %0d want 0 0 0", rx_count, rx_err_cnt - e0, tx_err_cnt - t0); end
      send_frame(8'h1C, 1'b0, 1'b0, 0);
      compared++; if (key_out !== 10'h01C || rx_count !== 4'd1) begin mismatched++; $display("FAIL to_recover: got %h/%0d want 01c/1", key_out, rx_count); end
      pop_one();
   endtask

   task automatic test_reset_mid_tx();
      logic rdy1, start_oe;
      int inh;
      start_tx(8'h00, rdy1, inh, start_oe);
      wait_cyc(10);
      for (int k = 0; k < 3; k++) begin
         wait_cyc(H); dev_clk_low = 1'b1; wait_cyc(H); dev_clk_low = 1'b0;
      end
      wait_cyc(5);
      compared++; if (ps2_data_oe !== 1'b1 || tx_ready !== 1'b0) begin mismatched++; $display("FAIL midtx_driving: data_oe %b ready %b want 1 0", ps2_data_oe, tx_ready); end
      #2 rst_n = 1'b0;
      #1;
      compared++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin mismatched++; $display("FAIL midtx_release: clk_oe %b data_oe %b want 0 0", ps2_clk_oe, ps2_data_oe); end
      compared++; if (tx_ready !== 1'b1) begin mismatched++; $display("FAIL midtx_ready: got %b want 1", tx_ready); end
      wait_cyc(3);
      rst_n = 1'b1;
      wait_cyc(40);
      compared++; if (rx_count !== 4'd0 || tx_ready !== 1'b1) begin mismatched++; $display("FAIL midtx_after: count %0d ready %b want 0 1", rx_count, tx_ready); end
   endtask

   initial begin
      test_reset();
      test_rx_basic();
      test_prefix();
      test_errors();
      test_overflow();
      test_tx(1'b1);
      test_tx(1'b0);
      test_device_response();
      test_timeout();
      test_reset_mid_tx();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
